// File: rtl/dtree_pkg.sv
// Shared constants and state encoding for the decision-tree feature loader.
// Feature indices are tied to the trained tree model.
package dtree_pkg;

  localparam int W            = 8;
  localparam int CLASS_W      = 5;
  localparam int NUM_FEATURES = 279;
  localparam int CNT_W        = $clog2(NUM_FEATURES);

  localparam int IDX0 = 13;
  localparam int IDX1 = 27;
  localparam int IDX2 = 235;
  localparam int IDX3 = 264;
  localparam int IDX4 = 278;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/dtree_feature_loader_if.sv
// Bundles the loader's stream input, feature-vector output and class result signals.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface dtree_feature_loader_if;
  import dtree_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [W-1:0]       s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [W-1:0]       feat0;
  logic [W-1:0]       feat1;
  logic [W-1:0]       feat2;
  logic [W-1:0]       feat3;
  logic [W-1:0]       feat4;
  logic [CLASS_W-1:0] class_in;
  logic [CLASS_W-1:0] class_out;
  logic               class_valid;
  logic               frame_err;

  // Loader side.
  modport slave (
    input  s_valid, s_data, s_last, m_ready, class_in,
    output s_ready, m_valid, feat0, feat1, feat2, feat3, feat4,
           class_out, class_valid, frame_err
  );

  // Environment side: feeds beats and consumes the vector.
  modport master (
    output s_valid, s_data, s_last, m_ready, class_in,
    input  s_ready, m_valid, feat0, feat1, feat2, feat3, feat4,
           class_out, class_valid, frame_err
  );

endinterface

// File: rtl/dtree_feature_loader.sv
// Collects one frame of raw features, captures the five the tree uses and holds them
// stable under m_valid/m_ready; registers the tree's class and flags malformed frames.
module dtree_feature_loader
  import dtree_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  dtree_feature_loader_if.slave  bus,
  output state_t                 dbg_state
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               s_ready_c;
  logic               m_valid_c;
  logic               capture_en;
  logic               err_set;
  logic               cls_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    s_ready_c  = 1'b0;
    m_valid_c  = 1'b0;
    capture_en = 1'b0;
    err_set    = 1'b0;
    cls_load   = 1'b0;
    case (state)
      COLLECT: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          capture_en = 1'b1;
          if (cnt == LAST_IDX) begin
            if (bus.s_last) begin
              cnt_nxt   = '0;
              state_nxt = HOLD;
            end else begin
              // Overlong frame: the rest of it is swallowed in DRAIN.
              err_set   = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (bus.s_last) begin
            err_set = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        m_valid_c = 1'b1;
        if (bus.m_ready) begin
          cls_load  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      DRAIN: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && bus.s_last) begin
          cnt_nxt   = '0;
          state_nxt = COLLECT;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = COLLECT;
      end
    endcase
  end

  // Each index compare is independent so several captures could share one beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.feat0 <= '0;
      bus.feat1 <= '0;
      bus.feat2 <= '0;
      bus.feat3 <= '0;
      bus.feat4 <= '0;
    end else if (capture_en) begin
      if (cnt == CNT_W'(IDX0)) bus.feat0 <= bus.s_data;
      if (cnt == CNT_W'(IDX1)) bus.feat1 <= bus.s_data;
      if (cnt == CNT_W'(IDX2)) bus.feat2 <= bus.s_data;
      if (cnt == CNT_W'(IDX3)) bus.feat3 <= bus.s_data;
      if (cnt == CNT_W'(IDX4)) bus.feat4 <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.class_out   <= '0;
      bus.class_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      bus.class_valid <= cls_load;
      bus.frame_err   <= err_set;
      if (cls_load) bus.class_out <= bus.class_in;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign dbg_state   = state;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader: nominal, backpressure, handshake,
// early-last, overlong and async-reset frames against hand-computed features.
module tb_dtree_feature_loader;
  import dtree_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  dtree_feature_loader_if bus ();

  dtree_feature_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int err_pulses = 0;
  int cv_pulses  = 0;

  logic [5*W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.frame_err)   err_pulses++;
    if (bus.class_valid) cv_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Beat i carries: mode 0 -> i[7:0], 1 -> 8'hFF, 2 -> 8'h55, 3 -> (i+1)[7:0].
  function automatic logic [W-1:0] beat_data(input int i, input int mode);
    int v;
    case (mode)
      1:       v = 255;
      2:       v = 85;
      3:       v = i + 1;
      default: v = i;
    endcase
    return W'(v & 255);
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int budget;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    budget = 20;
    while (!bus.s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.s_ready) check("beat_accept_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int last_at, input int mode);
    for (int i = 0; i < n; i++) send_beat(beat_data(i, mode), (i == last_at));
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_vec(input string tag);
    logic [5*W-1:0] exp_v;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      exp_v = exp_q.pop_front();
      check(tag, 64'({bus.feat4, bus.feat3, bus.feat2, bus.feat1, bus.feat0}), 64'(exp_v));
    end
  endtask

  task automatic handshake(input logic [CLASS_W-1:0] cls, input string tag);
    int cv0;
    cv0 = cv_pulses;
    bus.class_in = cls;
    bus.m_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.m_ready = 1'b0;
    check({tag, "_class_valid"}, 64'(bus.class_valid), 64'd1);
    check({tag, "_class_out"}, 64'(bus.class_out), 64'(cls));
    check({tag, "_m_valid_low"}, 64'(bus.m_valid), 64'd0);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    check({tag, "_class_valid_1cyc"}, 64'(cv_pulses - cv0), 64'd1);
    check({tag, "_class_hold"}, 64'(bus.class_out), 64'(cls));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    int bad;
    rst_n        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b0;
    bus.class_in = '0;
    repeat (3) @(negedge clk);

    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    check("rst_class_valid", 64'(bus.class_valid), 64'd0);
    check("rst_frame_err", 64'(bus.frame_err), 64'd0);
    check("rst_class_out", 64'(bus.class_out), 64'd0);
    check("rst_feats", 64'({bus.feat4, bus.feat3, bus.feat2, bus.feat1, bus.feat0}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(COLLECT));
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frame: data = index[7:0].
    exp_q.push_back({8'd22, 8'd8, 8'd235, 8'd27, 8'd13});
    e0 = err_pulses;
    send_frame(NUM_FEATURES, NUM_FEATURES - 1, 0);
    check("nom_m_valid", 64'(bus.m_valid), 64'd1);
    check("nom_s_ready", 64'(bus.s_ready), 64'd0);
    check_vec("nom_feats");
    check("nom_no_err", 64'(err_pulses - e0), 64'd0);

    // Backpressure with an eager upstream.
    bad = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.m_valid || bus.s_ready || bus.class_valid ||
          {bus.feat4, bus.feat3, bus.feat2, bus.feat1, bus.feat0} !== {8'd22, 8'd8, 8'd235, 8'd27, 8'd13})
        bad++;
    end
    bus.s_valid = 1'b0;
    check("bp_stable", 64'(bad), 64'd0);

    handshake(5'd17, "hs1");

    // All-ones frame.
    exp_q.push_back({5{8'hFF}});
    send_frame(NUM_FEATURES, NUM_FEATURES - 1, 1);
    check("ff_m_valid", 64'(bus.m_valid), 64'd1);
    check_vec("ff_feats");
    handshake(5'd5, "hs2");

    // Early last on beat 100: feat0/feat1 already overwritten with 0x55.
    e0 = err_pulses;
    send_frame(101, 100, 2);
    check("early_err_pulse", 64'(bus.frame_err), 64'd1);
    check("early_no_m_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    check("early_err_1cyc", 64'(err_pulses - e0), 64'd1);
    check("early_feats", 64'({bus.feat4, bus.feat3, bus.feat2, bus.feat1, bus.feat0}),
          64'({8'hFF, 8'hFF, 8'hFF, 8'h55, 8'h55}));
    exp_q.push_back({8'd22, 8'd8, 8'd235, 8'd27, 8'd13});
    send_frame(NUM_FEATURES, NUM_FEATURES - 1, 0);
    check("early_next_m_valid", 64'(bus.m_valid), 64'd1);
    check_vec("early_next_feats");
    check("early_next_no_err", 64'(err_pulses - e0), 64'd1);
    handshake(5'd9, "hs3");

    // Overlong: 291 beats, s_last only on beat 290.
    e0 = err_pulses;
    send_frame(291, 290, 0);
    check("long_err_once", 64'(err_pulses - e0), 64'd1);
    check("long_no_m_valid", 64'(bus.m_valid), 64'd0);
    check("long_back_collect", 64'(dbg_state), 64'(COLLECT));
    exp_q.push_back({8'd23, 8'd9, 8'd236, 8'd28, 8'd14});
    send_frame(NUM_FEATURES, NUM_FEATURES - 1, 3);
    check("long_next_m_valid", 64'(bus.m_valid), 64'd1);
    check_vec("long_next_feats");
    check("long_no_extra_err", 64'(err_pulses - e0), 64'd1);
    handshake(5'd30, "hs4");

    // Async reset between edges in the middle of a frame.
    e0 = err_pulses;
    send_frame(150, -1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_feats", 64'({bus.feat4, bus.feat3, bus.feat2, bus.feat1, bus.feat0}), 64'd0);
    check("mid_rst_class_out", 64'(bus.class_out), 64'd0);
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'd1);
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({8'd22, 8'd8, 8'd235, 8'd27, 8'd13});
    send_frame(NUM_FEATURES, NUM_FEATURES - 1, 0);
    check("post_rst_m_valid", 64'(bus.m_valid), 64'd1);
    check_vec("post_rst_feats");
    check("post_rst_no_err", 64'(err_pulses - e0), 64'd0);
    handshake(5'd1, "hs5");

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
